// File: rtl/program_sequencer_if.sv
// Control-side bundle for program_sequencer: branch controls in, program counter and stack status out.
interface program_sequencer_if #(
   parameter int AW = 8
);
   logic          en;
   logic          tcnd;
   logic          jmp;
   logic          call;
   logic          ret;
   logic [AW-1:0] jadr;
   logic [AW-1:0] pc;
   logic [4:0]    sdep;
   logic          err;

   modport master (
      output en, tcnd, jmp, call, ret, jadr,
      input  pc, sdep, err
   );

   modport slave (
      input  en, tcnd, jmp, call, ret, jadr,
      output pc, sdep, err
   );
endinterface

// File: rtl/program_sequencer.sv
// Program counter / branch sequencer with optional call/return stack and sticky misuse flag.
// Define SEQ_RETURN_STACK_EN to build the return stack; otherwise call acts as jmp and ret as a no-op.
module program_sequencer #(
   parameter int AW = 8,
   parameter int SD = 4
) (
   input logic                clk,
   input logic                rst,
   program_sequencer_if.slave bus
);

   logic [AW-1:0] pc_reg;
   logic [AW-1:0] pc_next;
   logic          err_reg;
   logic          err_next;
   logic [AW-1:0] pc_inc;
   logic          multi;

   assign pc_inc = pc_reg + 1'b1;
   assign multi  = (bus.jmp & bus.call) | (bus.jmp & bus.ret) | (bus.call & bus.ret);

`ifdef SEQ_RETURN_STACK_EN
   logic [AW-1:0] stack_mem [SD];
   logic [4:0]    sdep_reg;
   logic [4:0]    sdep_next;
   logic [AW-1:0] top;
   logic          push;

   // Pointer equals depth, so the top entry lives at sdep-1.
   always_comb begin
      top = '0;
      for (int i = 0; i < SD; i++) begin
         if (sdep_reg == 5'(i + 1)) top = stack_mem[i];
      end
   end

   always_comb begin
      pc_next   = pc_reg;
      err_next  = err_reg;
      sdep_next = sdep_reg;
      push      = 1'b0;
      if (bus.en) begin
         pc_next = pc_inc;
         if (multi) begin
            err_next = 1'b1;
         end else if (bus.ret) begin
            if (sdep_reg != 5'd0) begin
               pc_next   = top;
               sdep_next = sdep_reg - 5'd1;
            end else begin
               err_next = 1'b1;
            end
         end else if (bus.call && bus.tcnd) begin
            if (sdep_reg < 5'(SD)) begin
               push      = 1'b1;
               pc_next   = bus.jadr;
               sdep_next = sdep_reg + 5'd1;
            end else begin
               err_next = 1'b1;
            end
         end else if (bus.jmp && bus.tcnd) begin
            pc_next = bus.jadr;
         end
      end
   end

   // Stack contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < SD; i++) begin
         if (push && sdep_reg == 5'(i)) stack_mem[i] <= pc_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) sdep_reg <= '0;
      else     sdep_reg <= sdep_next;
   end

   assign bus.sdep = sdep_reg;
`else
   always_comb begin
      pc_next  = pc_reg;
      err_next = err_reg;
      if (bus.en) begin
         pc_next = pc_inc;
         if (multi) begin
            err_next = 1'b1;
         end else if ((bus.jmp || bus.call) && bus.tcnd) begin
            pc_next = bus.jadr;
         end
      end
   end

   assign bus.sdep = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg  <= '0;
         err_reg <= 1'b0;
      end else begin
         pc_reg  <= pc_next;
         err_reg <= err_next;
      end
   end

   assign bus.pc  = pc_reg;
   assign bus.err = err_reg;

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Program-counter and branch sequencer for the 8-bit datapath, directly downstream of the condition code system. Each cycle it takes the condition result `tcnd`, the decoded branch class and the jump target, and produces the next instruction address. It keeps a small hardware return stack for call/return, and it flags stack misuse with a sticky error bit.

## Interface

Parameters:
- `AW`, 8: address width of `pc` and `jadr`.
- `SD`, 4: return-stack depth in entries, 1..16.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  advance enable; low = stall, all state holds.
- `tcnd`  in  1  condition result from the condition code system, sampled the same cycle.
- `jmp`  in  1  current instruction is a jump or branch.
- `call`  in  1  current instruction is a call.
- `ret`  in  1  current instruction is a return.
- `jadr`  in  AW  jump or call target.
- `pc`  out  AW  current instruction address (registered).
- `sdep`  out  5  number of valid return-stack entries, 0..SD.
- `err`  out  1  sticky stack error; cleared only by `rst`.

## Operation

- Reset (`rst`=1 at the edge): `pc`=0, `sdep`=0, `err`=0, stack contents don't-care. Reset overrides `en` and every other input.
- `en`=0: `pc`, stack, `sdep` and `err` all hold. `jmp`, `call` and `ret` are ignored.
- `en`=1, next-`pc` selection in priority order:
  1. More than one of `jmp`, `call`, `ret` asserted: illegal. `pc` <= `pc`+1, `err` <= 1, stack unchanged.
  2. `ret`, `sdep`>0: `pc` <= top entry, `sdep` decrements. `tcnd` is ignored.
  3. `ret`, `sdep`=0 (underflow): `pc` <= `pc`+1, `err` <= 1.
  4. `call`, `tcnd`=1, `sdep`<SD: push `pc`+1, `pc` <= `jadr`, `sdep` increments.
  5. `call`, `tcnd`=1, `sdep`=SD (overflow): no push, call not taken, `pc` <= `pc`+1, `err` <= 1.
  6. `call` with `tcnd`=0, or `jmp` with `tcnd`=0: `pc` <= `pc`+1.
  7. `jmp`, `tcnd`=1: `pc` <= `jadr`.
  8. No control asserted: `pc` <= `pc`+1.
- Arithmetic: `pc`+1 is modulo 2^AW, so 8'hFF+1 = 8'h00. A pushed return address wraps the same way.
- The stack is LIFO: a register array plus a pointer equal to `sdep`. Push writes entry `sdep`; pop reads entry `sdep`-1.
- `err` is set-only. Once set it stays at 1 through further legal operations until `rst`.

## Timing

- `pc` changes exactly one cycle after the edge at which the inputs are sampled. Taken-branch latency is 1 cycle with no bubble inserted by this block.
- `tcnd` is combinational from the condition code system and must be settled before the same edge.
- `sdep` and `err` update on the same edge as `pc`.
- Reset mid-operation: the `rst` edge wins over a simultaneous push or pop. The cycle after reset, `pc`=0 and the stack is empty.
- Stall then release: the instruction presented during the first `en`=1 cycle is the one that executes. Nothing is queued during a stall.

## Configuration

- Macro `SEQ_RETURN_STACK_EN`.
- Defined: return stack, `call`/`ret` handling and `err` behave as specified above.
- Undefined:
  - No stack storage is built.
  - `call` behaves exactly like `jmp` (`jadr` if `tcnd`=1, else `pc`+1).
  - `ret` behaves as a no-op (`pc`+1).
  - `sdep` is tied to 0.
  - `err` is set only by rule 1 (multiple controls asserted).

## Test plan

- Reset and increment: `rst` for 1 cycle, then 300 cycles with no controls -> `pc` counts 0,1,…,255,0,…,43. `sdep`=0, `err`=0 throughout.
- Conditional jump: at `pc`=5, `jmp`=1, `jadr`=8'h40, `tcnd`=0 -> `pc`=6. Repeat at 6 with `tcnd`=1 -> `pc`=8'h40 next cycle.
- Call/return nest: call to 8'h20 at `pc`=3, then to 8'h30 at `pc`=8'h21, then ret, ret -> `pc` sequence 8'h20, 8'h21, 8'h30, 8'h22, 4. `sdep` goes 1, 2, 1, 0. `err`=0.
- Overflow and underflow (SD=4):
  - Five taken calls -> the fifth gives `pc`+1, `sdep` stays 4, `err`=1.
  - After `rst`, a ret at `pc`=0 -> `pc`=1, `err`=1.
- Stall and illegal combination:
  - `en`=0 for 3 cycles with `jmp`=1, `tcnd`=1 -> `pc` holds.
  - `jmp`=1 and `call`=1 together with `en`=1 -> `pc`+1, `err`=1, `sdep` unchanged.
- Reset mid-call: `rst` asserted on the same edge as a taken call with `sdep`=2 -> next cycle `pc`=0, `sdep`=0, `err`=0.
